// File: rtl/lcd_pkg.sv
// Shared definitions for the LCD panel power sequencer: state encoding,
// default timing constants and output-decode helpers.
package lcd_pkg;

  typedef enum logic [2:0] {
    ST_OFF      = 3'd0,
    ST_DISP_UP  = 3'd1,
    ST_FRAME_UP = 3'd2,
    ST_BL_UP    = 3'd3,
    ST_ON       = 3'd4,
    ST_BL_DN    = 3'd5,
    ST_FRAME_DN = 3'd6,
    ST_DISP_DN  = 3'd7
  } lcd_seq_state_t;

  localparam int LCD_T_DISP   = 1000;
  localparam int LCD_T_BL     = 5000;
  localparam int LCD_FRAME_TO = 600000;

  // Enable pattern for a state, packed as {disp, timing_en, video_en, back_led_en}.
  function automatic logic [3:0] lcd_enables(lcd_seq_state_t s);
    logic [3:0] en;
    case (s)
      ST_OFF:      en = 4'b0000;
      ST_DISP_UP:  en = 4'b1000;
      ST_FRAME_UP: en = 4'b1100;
      ST_BL_UP:    en = 4'b1110;
      ST_ON:       en = 4'b1111;
      ST_BL_DN:    en = 4'b1110;
      ST_FRAME_DN: en = 4'b1110;
      ST_DISP_DN:  en = 4'b1000;
      default:     en = 4'b0000;
    endcase
    return en;
  endfunction

  // Sequencer is busy anywhere except the two resting states.
  function automatic logic lcd_is_busy(lcd_seq_state_t s);
    return (s != ST_OFF) && (s != ST_ON);
  endfunction

endpackage

// File: rtl/lcd_dwell_timer.sv
// Dwell / timeout counter. Counts cycles since the last clear; done is high
// on the cycle the count equals limit-1, so a limit of T marks the T-th
// cycle after a clear. Saturates instead of wrapping.
module lcd_dwell_timer #(
  parameter int CNT_W = 20
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic [CNT_W-1:0] limit,
  output logic             done
);

  localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

  logic [CNT_W-1:0] cnt_r;

  // Cycle counter: restart on clear, otherwise count up and hold at max.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_r <= CNT_ZERO;
    end else if (clear) begin
      cnt_r <= CNT_ZERO;
    end else if (cnt_r != CNT_MAX) begin
      cnt_r <= cnt_r + CNT_ONE;
    end else begin
      cnt_r <= cnt_r;
    end
  end

  assign done = (cnt_r == (limit - CNT_ONE));

endmodule

// File: rtl/lcd_power_seq.sv
// LCD panel power/enable sequencer (pixel clock domain).
// Power-up: disp -> timing_en -> video_en (at frame start) -> backlight;
// power-down mirrors it. Abort/resume jumps to the mirror state.
// Optional feature macro: LCD_SEQ_PWM_EN (backlight PWM in ON state).
module lcd_power_seq
  import lcd_pkg::*;
#(
  parameter int T_DISP   = LCD_T_DISP,
  parameter int T_BL     = LCD_T_BL,
  parameter int FRAME_TO = LCD_FRAME_TO,
  parameter int CNT_W    = 20,
  parameter int PWM_W    = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             pwr_req,
  input  logic             frame_start,
  input  logic [PWM_W-1:0] bl_duty,
  output logic             disp,
  output logic             timing_en,
  output logic             video_en,
  output logic             back_led_en,
  output logic             busy,
  output logic             fault
);

  localparam logic [CNT_W-1:0] LIM_DISP  = CNT_W'(T_DISP);
  localparam logic [CNT_W-1:0] LIM_BL    = CNT_W'(T_BL);
  localparam logic [CNT_W-1:0] LIM_FRAME = CNT_W'(FRAME_TO);

  lcd_seq_state_t   state_r;
  lcd_seq_state_t   state_nxt_s;
  logic             fault_r;
  logic             fault_nxt_s;
  logic             disp_r;
  logic             timing_en_r;
  logic             video_en_r;
  logic             back_led_en_r;
  logic             busy_r;
  logic             clear_s;
  logic             done_s;
  logic [CNT_W-1:0] limit_s;
  logic [3:0]       en_nxt_s;
  logic             pwm_on_s;

  // Dwell length for the current state: frame states use the timeout.
  always_comb begin
    limit_s = LIM_DISP;
    case (state_r)
      ST_DISP_UP, ST_DISP_DN:   limit_s = LIM_DISP;
      ST_BL_UP, ST_BL_DN:       limit_s = LIM_BL;
      ST_FRAME_UP, ST_FRAME_DN: limit_s = LIM_FRAME;
      default:                  limit_s = LIM_DISP;
    endcase
  end

  // Any state change (including abort/resume jumps) restarts the dwell.
  assign clear_s = (state_nxt_s != state_r);

  lcd_dwell_timer #(
    .CNT_W (CNT_W)
  ) u_dwell (
    .clk   (clk),
    .rst   (rst),
    .clear (clear_s),
    .limit (limit_s),
    .done  (done_s)
  );

  // Next-state logic; pwr_req reversal has priority over dwell completion.
  always_comb begin
    state_nxt_s = state_r;
    fault_nxt_s = fault_r;
    case (state_r)
      ST_OFF: begin
        if (pwr_req) begin
          state_nxt_s = ST_DISP_UP;
          fault_nxt_s = 1'b0;
        end else begin
          state_nxt_s = ST_OFF;
        end
      end
      ST_DISP_UP: begin
        if (!pwr_req)    state_nxt_s = ST_DISP_DN;
        else if (done_s) state_nxt_s = ST_FRAME_UP;
        else             state_nxt_s = ST_DISP_UP;
      end
      ST_FRAME_UP: begin
        if (!pwr_req)         state_nxt_s = ST_DISP_DN;
        else if (frame_start) state_nxt_s = ST_BL_UP;
        else if (done_s) begin
          state_nxt_s = ST_DISP_DN;
          fault_nxt_s = 1'b1;
        end else begin
          state_nxt_s = ST_FRAME_UP;
        end
      end
      ST_BL_UP: begin
        if (!pwr_req)    state_nxt_s = ST_BL_DN;
        else if (done_s) state_nxt_s = ST_ON;
        else             state_nxt_s = ST_BL_UP;
      end
      ST_ON: begin
        if (!pwr_req) state_nxt_s = ST_BL_DN;
        else          state_nxt_s = ST_ON;
      end
      ST_BL_DN: begin
        if (pwr_req)     state_nxt_s = ST_BL_UP;
        else if (done_s) state_nxt_s = ST_FRAME_DN;
        else             state_nxt_s = ST_BL_DN;
      end
      ST_FRAME_DN: begin
        if (pwr_req)          state_nxt_s = ST_BL_UP;
        else if (frame_start) state_nxt_s = ST_DISP_DN;
        else if (done_s) begin
          state_nxt_s = ST_DISP_DN;
          fault_nxt_s = 1'b1;
        end else begin
          state_nxt_s = ST_FRAME_DN;
        end
      end
      ST_DISP_DN: begin
        if (pwr_req)     state_nxt_s = ST_DISP_UP;
        else if (done_s) state_nxt_s = ST_OFF;
        else             state_nxt_s = ST_DISP_DN;
      end
      default: begin
        state_nxt_s = ST_OFF;
        fault_nxt_s = fault_r;
      end
    endcase
  end

  assign en_nxt_s = lcd_enables(state_nxt_s);

`ifdef LCD_SEQ_PWM_EN
  localparam logic [PWM_W-1:0] PWM_ONE  = {{(PWM_W-1){1'b0}}, 1'b1};
  localparam logic [PWM_W-1:0] PWM_ZERO = {PWM_W{1'b0}};

  logic [PWM_W-1:0] pwm_cnt_r;
  logic [PWM_W-1:0] duty_r;
  logic [PWM_W-1:0] duty_eff_s;

  // Free-running PWM period counter; duty latched only at period start.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pwm_cnt_r <= PWM_ZERO;
      duty_r    <= PWM_ZERO;
    end else begin
      pwm_cnt_r <= pwm_cnt_r + PWM_ONE;
      if (pwm_cnt_r == PWM_ZERO) duty_r <= bl_duty;
      else                       duty_r <= duty_r;
    end
  end

  assign duty_eff_s = (pwm_cnt_r == PWM_ZERO) ? bl_duty : duty_r;
  assign pwm_on_s   = (pwm_cnt_r < duty_eff_s);
`else
  logic unused_bl_duty_s;
  assign unused_bl_duty_s = ^bl_duty;
  assign pwm_on_s         = 1'b1;
`endif

  // State register and registered output decode of the next state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r       <= ST_OFF;
      fault_r       <= 1'b0;
      disp_r        <= 1'b0;
      timing_en_r   <= 1'b0;
      video_en_r    <= 1'b0;
      back_led_en_r <= 1'b0;
      busy_r        <= 1'b0;
    end else begin
      state_r       <= state_nxt_s;
      fault_r       <= fault_nxt_s;
      disp_r        <= en_nxt_s[3];
      timing_en_r   <= en_nxt_s[2];
      video_en_r    <= en_nxt_s[1];
      back_led_en_r <= en_nxt_s[0] & pwm_on_s;
      busy_r        <= lcd_is_busy(state_nxt_s);
    end
  end

  assign disp        = disp_r;
  assign timing_en   = timing_en_r;
  assign video_en    = video_en_r;
  assign back_led_en = back_led_en_r;
  assign busy        = busy_r;
  assign fault       = fault_r;

endmodule

// File: tb/tb_lcd_power_seq.sv
// Directed testbench for lcd_power_seq with T_DISP=4, T_BL=3, FRAME_TO=50.
// Observed vector order: {disp, timing_en, video_en, back_led_en, busy, fault}.
// Window r = the interval just after the r-th clock edge following the
// moment the scenario's first input was applied (window 0).
module tb_lcd_power_seq;

  logic       clk;
  logic       rst;
  logic       pwr_req;
  logic       frame_start;
  logic [3:0] bl_duty;
  logic       disp;
  logic       timing_en;
  logic       video_en;
  logic       back_led_en;
  logic       busy;
  logic       fault;

  int n_cmp;
  int n_bad;

  lcd_power_seq #(
    .T_DISP   (4),
    .T_BL     (3),
    .FRAME_TO (50),
    .CNT_W    (20),
    .PWM_W    (4)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .pwr_req     (pwr_req),
    .frame_start (frame_start),
    .bl_duty     (bl_duty),
    .disp        (disp),
    .timing_en   (timing_en),
    .video_en    (video_en),
    .back_led_en (back_led_en),
    .busy        (busy),
    .fault       (fault)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [5:0] obs();
    return {disp, timing_en, video_en, back_led_en, busy, fault};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Drive from OFF to ON with a frame pulse in window 6; ends in window 10 (ON).
  task automatic bring_up();
    pwr_req = 1'b1;
    for (int w = 0; w < 10; w++) begin
      frame_start = (w == 6);
      step();
    end
    frame_start = 1'b0;
  endtask

  task automatic test_reset();
    logic [5:0] o;
    rst = 1'b1;
    pwr_req = 1'b0;
    frame_start = 1'b0;
    bl_duty = 4'd4;
    step();
    o = obs();
    n_cmp++;
    if (o !== 6'b000000) begin
      n_bad++;
      $display("FAIL reset_hold: got %b want %b", o, 6'b000000);
    end
    #2 rst = 1'b0;
    step();
    step();
    o = obs();
    n_cmp++;
    if (o !== 6'b000000) begin
      n_bad++;
      $display("FAIL reset_release: got %b want %b", o, 6'b000000);
    end
  endtask

  task automatic test_power_up();
    logic [5:0] o;
    logic [5:0] e;
    pwr_req = 1'b1;
    for (int r = 1; r <= 16; r++) begin
      frame_start = ((r - 1) == 2) || ((r - 1) == 10);
      step();
      frame_start = 1'b0;
      if (r <= 4)       e = 6'b100010;
      else if (r <= 10) e = 6'b110010;
      else if (r <= 13) e = 6'b111010;
      else              e = 6'b111100;
      o = obs();
      n_cmp++;
      if (o !== e) begin
        n_bad++;
        $display("FAIL power_up r=%0d: got %b want %b", r, o, e);
      end
    end
  endtask

  task automatic test_power_down();
    logic [5:0] o;
    logic [5:0] e;
    pwr_req = 1'b0;
    for (int r = 1; r <= 12; r++) begin
      frame_start = ((r - 1) == 2) || ((r - 1) == 6);
      step();
      frame_start = 1'b0;
      if (r <= 6)       e = 6'b111010;
      else if (r <= 10) e = 6'b100010;
      else              e = 6'b000000;
      o = obs();
      n_cmp++;
      if (o !== e) begin
        n_bad++;
        $display("FAIL power_down r=%0d: got %b want %b", r, o, e);
      end
    end
  endtask

  task automatic test_abort_resume();
    logic [5:0] o;
    logic [5:0] e;
    for (int r = 1; r <= 17; r++) begin
      pwr_req     = !(((r - 1) >= 7) && ((r - 1) < 12));
      frame_start = ((r - 1) == 6);
      step();
      frame_start = 1'b0;
      if (r <= 4)       e = 6'b100010;
      else if (r <= 6)  e = 6'b110010;
      else if (r <= 15) e = 6'b111010;
      else              e = 6'b111100;
      o = obs();
      n_cmp++;
      if (o !== e) begin
        n_bad++;
        $display("FAIL abort_resume r=%0d: got %b want %b", r, o, e);
      end
    end
  endtask

  task automatic test_frame_timeout();
    logic [5:0] o;
    logic [5:0] e;
    frame_start = 1'b0;
    for (int r = 1; r <= 70; r++) begin
      pwr_req = ((r - 1) < 55) || ((r - 1) == 63);
      step();
      if (r <= 4)       e = 6'b100010;
      else if (r <= 54) e = 6'b110010;
      else if (r <= 58) e = 6'b100011;
      else if (r <= 63) e = 6'b000001;
      else if (r == 64) e = 6'b100010;
      else if (r <= 68) e = 6'b100010;
      else              e = 6'b000000;
      o = obs();
      n_cmp++;
      if (o !== e) begin
        n_bad++;
        $display("FAIL frame_timeout r=%0d: got %b want %b", r, o, e);
      end
    end
  endtask

  task automatic test_async_reset();
    logic [5:0] o;
    bring_up();
    o = obs();
    n_cmp++;
    if (o !== 6'b111100) begin
      n_bad++;
      $display("FAIL async_pre_on: got %b want %b", o, 6'b111100);
    end
    #2 rst = 1'b1;
    #1;
    o = obs();
    n_cmp++;
    if (o !== 6'b000000) begin
      n_bad++;
      $display("FAIL async_assert: got %b want %b", o, 6'b000000);
    end
    pwr_req = 1'b0;
    #2 rst = 1'b0;
    step();
    step();
    o = obs();
    n_cmp++;
    if (o !== 6'b000000) begin
      n_bad++;
      $display("FAIL async_after_release: got %b want %b", o, 6'b000000);
    end
    pwr_req = 1'b1;
    step();
    o = obs();
    n_cmp++;
    if (o !== 6'b100010) begin
      n_bad++;
      $display("FAIL async_restart: got %b want %b", o, 6'b100010);
    end
    pwr_req = 1'b0;
    for (int i = 0; i < 5; i++) step();
    o = obs();
    n_cmp++;
    if (o !== 6'b000000) begin
      n_bad++;
      $display("FAIL async_back_off: got %b want %b", o, 6'b000000);
    end
  endtask

`ifdef LCD_SEQ_PWM_EN
  task automatic test_pwm();
    int hi;
    bl_duty = 4'd4;
    bring_up();
    for (int i = 0; i < 3; i++) step();
    hi = 0;
    for (int i = 0; i < 32; i++) begin
      step();
      if (back_led_en === 1'b1) hi++;
    end
    n_cmp++;
    if (hi !== 8) begin
      n_bad++;
      $display("FAIL pwm_duty4: got %0d high of 32, want 8", hi);
    end
    bl_duty = 4'd0;
    for (int i = 0; i < 18; i++) step();
    hi = 0;
    for (int i = 0; i < 32; i++) begin
      step();
      if (back_led_en === 1'b1) hi++;
    end
    n_cmp++;
    if (hi !== 0) begin
      n_bad++;
      $display("FAIL pwm_duty0: got %0d high of 32, want 0", hi);
    end
    n_cmp++;
    if (video_en !== 1'b1) begin
      n_bad++;
      $display("FAIL pwm_still_on: got %b want 1", video_en);
    end
    bl_duty = 4'd4;
  endtask
`endif

  initial begin
    n_cmp = 0;
    n_bad = 0;
    test_reset();
    test_power_up();
    test_power_down();
    test_abort_resume();
    test_power_down();
    test_frame_timeout();
    test_async_reset();
`ifdef LCD_SEQ_PWM_EN
    test_pwm();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/lcd_power_seq.md
# lcd_power_seq

Power and enable sequencer for the RGB LCD panel path. Steps the panel through a fixed power-up order on request: display enable, timing generator run, video gate at a frame boundary, then backlight. Power-down runs the same steps in reverse. Sits between system control and the pixel-clock timing generator / panel pins, in the pixel clock domain.

## Interface
- `T_DISP`, default 1000: cycles from `disp` high to `timing_en` high, and from `timing_en` low to `disp` low. Must be ≥1.
- `T_BL`, default 5000: cycles from `video_en` high to backlight on, and from backlight off to video-off arming. Must be ≥1.
- `FRAME_TO`, default 600000: cycles to wait for `frame_start` before declaring a fault. Must be ≥1.
- `CNT_W`, default 20: dwell counter width. Must hold max(`T_DISP`, `T_BL`, `FRAME_TO`).
- `PWM_W`, default 8: backlight PWM resolution.
- `clk` in 1: pixel clock.
- `rst` in 1: reset, asynchronous, active-high.
- `pwr_req` in 1: level; 1 = panel on requested, 0 = off requested.
- `frame_start` in 1: one-cycle pulse from the timing generator at the start of each frame (vsync leading edge).
- `bl_duty` in `PWM_W`: backlight duty, used only with the PWM feature.
- `disp` out 1: panel display enable.
- `timing_en` out 1: run enable to the timing generator.
- `video_en` out 1: RGB data gate; 0 forces black.
- `back_led_en` out 1: backlight enable.
- `busy` out 1: high in every state except OFF and ON.
- `fault` out 1: sticky; set on a frame timeout.

## Operation
- States: OFF, DISP_UP, FRAME_UP, BL_UP, ON, BL_DN, FRAME_DN, DISP_DN.
- Output decode, all outputs registered:
  - OFF: all outputs 0.
  - DISP_UP: `disp` = 1.
  - FRAME_UP: `disp` and `timing_en` = 1.
  - BL_UP: `disp`, `timing_en` and `video_en` = 1.
  - ON: all four enables = 1.
  - BL_DN: same as BL_UP.
  - FRAME_DN: same as BL_UP.
  - DISP_DN: `disp` = 1 only.
- Power-up path:
  - OFF → DISP_UP when `pwr_req` = 1.
  - DISP_UP → FRAME_UP after `T_DISP` cycles.
  - FRAME_UP → BL_UP on `frame_start`.
  - BL_UP → ON after `T_BL` cycles.
- Power-down path:
  - ON → BL_DN when `pwr_req` = 0.
  - BL_DN → FRAME_DN after `T_BL` cycles.
  - FRAME_DN → DISP_DN on `frame_start`.
  - DISP_DN → OFF after `T_DISP` cycles.
- Abort: `pwr_req` = 0 during power-up jumps to the mirror state:
  - DISP_UP → DISP_DN.
  - FRAME_UP → DISP_DN.
  - BL_UP → BL_DN.
- Resume: `pwr_req` = 1 during power-down jumps to the mirror state:
  - BL_DN → BL_UP.
  - FRAME_DN → BL_UP.
  - DISP_DN → DISP_UP.
- Abort/resume has priority over dwell completion in the same cycle.
- Dwell counter clears on every state entry, including abort/resume jumps. A dwell of T means exactly T cycles spent in the state.
- Frame timeout: FRAME_UP or FRAME_DN with no `frame_start` for `FRAME_TO` cycles sets `fault`.
  - FRAME_UP on timeout → DISP_DN.
  - FRAME_DN on timeout → DISP_DN.
- `fault` clears only on `rst` or on an OFF → DISP_UP transition.
- `frame_start` outside FRAME_UP/FRAME_DN is ignored.

## Timing
- Reset values: state OFF; `disp`, `timing_en`, `video_en`, `back_led_en`, `busy` and `fault` all 0; counters 0.
- State update and outputs change on the clock edge after the triggering input. `pwr_req` sampled at cycle n → state and outputs change at n+1.
- `frame_start` in FRAME_UP at cycle n → `video_en` = 1 at n+1. It is never asserted mid-frame.
- Minimum power-up latency from `pwr_req` rising: 1 + `T_DISP` + (wait for frame) + `T_BL` cycles to `back_led_en` = 1.
- `rst` mid-sequence drops all outputs to 0 immediately (asynchronous). There is no ordered shutdown.

## Configuration
- `LCD_SEQ_PWM_EN` defined:
  - Free-running `PWM_W`-bit counter.
  - In ON, `back_led_en` = (pwm_cnt < `bl_duty`). Duty 0 gives always off.
  - `bl_duty` is sampled when pwm_cnt = 0, so there are no glitches mid-period.
- `LCD_SEQ_PWM_EN` undefined:
  - `back_led_en` = 1 exactly in ON.
  - `bl_duty` is ignored and no PWM counter exists.

## Structure
- Shared package `lcd_pkg`: state enumeration `lcd_seq_state_t` and default constants `LCD_T_DISP`, `LCD_T_BL`, `LCD_FRAME_TO`.
- One sub-module, `lcd_dwell_timer`:
  - Inputs: `clk`, `rst`, `clear`, `limit`.
  - Output: `done`, high on the cycle the count reaches `limit` − 1.
  - Used for both dwell and timeout counting.

## Test plan
- Test parameters: `T_DISP` = 4, `T_BL` = 3, `FRAME_TO` = 50.
- Normal power-up: `pwr_req` 0→1 at cycle 10, `frame_start` at cycle 20.
  - `disp` rises at 11, `timing_en` at 15, `video_en` at 21, `back_led_en` at 24.
  - `busy` falls at 24.
- Normal power-down from ON: `pwr_req` 1→0 at cycle n.
  - `back_led_en` falls at n+1.
  - `video_en` falls 1 cycle after the first `frame_start` at or after n+4.
  - `disp` falls 4 cycles after `video_en`.
- Abort in BL_UP: drop `pwr_req` one cycle into BL_UP.
  - Enters BL_DN and `back_led_en` never rises.
  - Resume with `pwr_req` = 1 in FRAME_DN → back to BL_UP.
- Frame timeout: no `frame_start` in FRAME_UP.
  - `fault` = 1 after 50 cycles, then DISP_DN, then OFF.
  - `fault` stays 1 until the next power-up.
- Async reset: assert `rst` mid-ON between clock edges.
  - All outputs 0 before the next edge; state OFF after release.
- PWM (`LCD_SEQ_PWM_EN`, `PWM_W` = 4): `bl_duty` = 4 in ON.
  - `back_led_en` high 4 of every 16 cycles.
  - `bl_duty` = 0 → constant low from the next period.
